// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back stage: selects the write-back value,
// drives the register-file write port once per instruction, and provides forwarding.
module writeback_stage #(
  parameter int W  = 16,
  parameter int RA = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3*W+2:0]    data_in,
  input  logic [RA-1:0]     rdst_in,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  output logic              rf_we,
  output logic [RA-1:0]     rf_waddr,
  output logic [W-1:0]      rf_wdata,
  output logic              fwd_valid,
  output logic [RA-1:0]     fwd_addr,
  output logic [W-1:0]      fwd_data,
  output logic [15:0]       retired,
  output logic              sel_err
);

  logic [2:0]    wb_q, wb_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [W-1:0]  alu_q, alu_d;
  logic [W-1:0]  mem_q, mem_d;
  logic [RA-1:0] rdst_q, rdst_d;
  logic          valid_q, valid_d;
  logic          fresh_q, fresh_d;
  logic [15:0]   retired_q, retired_d;
  logic          sel_err_q, sel_err_d;

  logic          sel_legal;
  logic          retire;
  logic [W-1:0]  wbv;

  assign sel_legal = (wb_q[1:0] != 2'b11);
  // fresh_q marks the first cycle an instruction occupies the register, so a stall never rewrites.
  assign retire    = valid_q & fresh_q;

  always_comb begin
    wbv = '0;
    unique case (wb_q[1:0])
      2'b00:   wbv = alu_q;
      2'b01:   wbv = mem_q;
      2'b10:   wbv = imm_q;
      default: wbv = '0;
    endcase
  end

  always_comb begin
    wb_d      = wb_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    mem_d     = mem_q;
    rdst_d    = rdst_q;
    valid_d   = valid_q;
    fresh_d   = 1'b0;
    retired_d = retired_q + {15'd0, retire};
    sel_err_d = sel_err_q | (retire & wb_q[2] & ~sel_legal);
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      wb_d    = data_in[3*W+2:3*W];
      imm_d   = data_in[3*W-1:2*W];
      alu_d   = data_in[2*W-1:W];
      mem_d   = data_in[W-1:0];
      rdst_d  = rdst_in;
      valid_d = valid_in;
      fresh_d = valid_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q      <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      mem_q     <= '0;
      rdst_q    <= '0;
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      retired_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      wb_q      <= wb_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      mem_q     <= mem_d;
      rdst_q    <= rdst_d;
      valid_q   <= valid_d;
      fresh_q   <= fresh_d;
      retired_q <= retired_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign rf_we     = retire & wb_q[2] & sel_legal;
  assign rf_waddr  = rdst_q;
  assign rf_wdata  = wbv;
  assign fwd_valid = valid_q & wb_q[2] & sel_legal;
  assign fwd_addr  = rdst_q;
  assign fwd_data  = wbv;
  assign retired   = retired_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios, random traffic
// against an instruction-level reference model, and retire-counter wrap.
module tb_writeback_stage;
  localparam int W  = 16;
  localparam int RA = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [3*W+2:0] data_in = '0;
  logic [RA-1:0]  rdst_in = '0;
  logic           valid_in = 1'b0;
  logic           stall = 1'b0;
  logic           flush = 1'b0;
  logic           rf_we;
  logic [RA-1:0]  rf_waddr;
  logic [W-1:0]   rf_wdata;
  logic           fwd_valid;
  logic [RA-1:0]  fwd_addr;
  logic [W-1:0]   fwd_data;
  logic [15:0]    retired;
  logic           sel_err;

  writeback_stage #(.W(W), .RA(RA)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .rdst_in(rdst_in),
    .valid_in(valid_in), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .retired(retired), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the instruction occupying WB, whether it has already had
  // its one write opportunity, and the architectural counters.
  bit        occ;
  bit        written;
  bit [2:0]  m_wb;
  bit [15:0] m_val [4];
  bit [2:0]  m_rd;
  int        m_ret;
  bit        m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    occ = 0; written = 1; m_wb = 0; m_rd = 0; m_ret = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_val[i] = 0;
  endfunction

  task automatic check_outputs(input string tag);
    bit writes, legal;
    bit [15:0] v;
    legal  = (m_wb[1:0] != 2'd3);
    writes = occ && !written && m_wb[2] && legal;
    v      = m_val[m_wb[1:0]];
    check({tag, ".rf_we"},     rf_we,     writes);
    check({tag, ".rf_waddr"},  rf_waddr,  m_rd);
    check({tag, ".rf_wdata"},  rf_wdata,  v);
    check({tag, ".fwd_valid"}, fwd_valid, occ && m_wb[2] && legal);
    check({tag, ".fwd_addr"},  fwd_addr,  m_rd);
    check({tag, ".fwd_data"},  fwd_data,  v);
    check({tag, ".retired"},   retired,   m_ret[15:0]);
    check({tag, ".sel_err"},   sel_err,   m_err);
  endtask

  // Called at a negedge: apply inputs, clock once, advance the model, check.
  task automatic cycle(input string tag, input bit v, input bit st, input bit fl,
                       input bit [2:0] wb, input bit [15:0] imm, input bit [15:0] alu,
                       input bit [15:0] mem, input bit [2:0] rd);
    data_in = {wb, imm, alu, mem}; rdst_in = rd; valid_in = v; stall = st; flush = fl;
    @(posedge clk);
    if (occ && !written) begin
      m_ret = (m_ret + 1) % 65536;
      if (m_wb == 3'b111) m_err = 1;
    end
    written = 1;
    if (fl) occ = 0;
    else if (!st) begin
      occ = v; written = !v; m_wb = wb; m_rd = rd;
      m_val[0] = alu; m_val[1] = mem; m_val[2] = imm; m_val[3] = 0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic rand_inputs();
    data_in = {$urandom, $urandom}; rdst_in = RA'($urandom);
    valid_in = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(posedge clk); #1;
      check_outputs("rst_hold");
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // first instruction and latency
    cycle("alu_op", 1, 0, 0, 3'b100, 16'h0, 16'h1234, 16'h0, 3'd5);
    cycle("alu_ret", 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0, 3'd0);

    // source select, back-to-back
    cycle("sel_alu", 1, 0, 0, 3'b100, 16'hCCCC, 16'hAAAA, 16'hBBBB, 3'd1);
    cycle("sel_mem", 1, 0, 0, 3'b101, 16'hCCCC, 16'hAAAA, 16'hBBBB, 3'd2);
    cycle("sel_imm", 1, 0, 0, 3'b110, 16'hCCCC, 16'hAAAA, 16'hBBBB, 3'd3);

    // stall holds: one write, forwarding persists, single retire
    cycle("stl_load", 1, 0, 0, 3'b101, 16'h0, 16'h0, 16'h00FF, 3'd2);
    for (int i = 0; i < 3; i++)
      cycle("stl_hold", 1, 1, 0, 3'b100, 16'h1, 16'h2, 16'h3, 3'd7);
    cycle("stl_end", 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0, 3'd0);

    // flush wins over stall
    cycle("fl_load", 1, 0, 0, 3'b100, 16'h0, 16'h5555, 16'h0, 3'd4);
    cycle("fl_both", 1, 1, 1, 3'b100, 16'h0, 16'h6666, 16'h0, 3'd6);
    cycle("fl_after", 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0, 3'd0);

    // illegal select is sticky
    cycle("ill_load", 1, 0, 0, 3'b111, 16'h1, 16'h2, 16'h3, 3'd1);
    cycle("ill_ret", 1, 0, 0, 3'b100, 16'h0, 16'h7777, 16'h0, 3'd2);
    cycle("ill_keep", 1, 0, 0, 3'b000, 16'h0, 16'h8888, 16'h0, 3'd3);

    // reset in the same cycle a commit is pending
    cycle("mid_load", 1, 0, 0, 3'b100, 16'h0, 16'h9999, 16'h0, 3'd5);
    do_reset();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bit st, fl;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      cycle("rand", 1'($urandom), st, fl, 3'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 3'($urandom));
    end

    // counter wrap, including ops without regWrite
    do_reset();
    for (int i = 0; i < 65535; i++)
      cycle("wrap_fill", 1, 0, 0, {1'($urandom), 1'b0, 1'($urandom)},
            16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
    cycle("wrap_last", 1, 0, 0, 3'b000, 16'h0, 16'h4321, 16'h0, 3'd6);
    check("wrap_ffff", retired, 16'hFFFF);
    cycle("wrap_zero", 0, 0, 0, 3'b000, 16'h0, 16'h0, 16'h0, 3'd0);
    check("wrap_0000", retired, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (WB) stage of the five-stage pipeline. Latches the memory stage's 51-bit output bundle plus destination register index into the MEM/WB pipeline register. Selects the write-back value (ALU result, memory read data, or immediate) and drives the register-file write port exactly once per instruction. Exposes a forwarding port and a retired-instruction counter. Supports stall (hold) and flush (bubble) from the hazard unit.

## Interface
Parameters:
- W, 16, datapath width
- RA, 3, register index width (8 registers)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- data_in  input  3*W+3  memory-stage bundle; [50:48] WB ctrl, [47:32] Imm, [31:16] ALU, [15:0] mem read data
- rdst_in  input  RA  destination register index travelling with data_in
- valid_in  input  1  data_in holds a real instruction
- stall  input  1  hold MEM/WB register contents
- flush  input  1  squash: load a bubble
- rf_we  output  1  register-file write enable
- rf_waddr  output  RA  register-file write address
- rf_wdata  output  W  register-file write data
- fwd_valid  output  1  forwarding data valid (WB hazard source)
- fwd_addr  output  RA  forwarded register index
- fwd_data  output  W  forwarded value
- retired  output  16  count of committed instructions
- sel_err  output  1  sticky illegal write-back select flag

## Operation
- WB control decode: WB[2] = regWrite; WB[1:0] = source: 00 ALU, 01 mem, 10 Imm, 11 illegal.
- MEM/WB register holds: WB ctrl, Imm, ALU, mem, rdst, valid_q, fresh_q.
- Per rising edge, priority flush > stall > load:
  - flush=1: valid_q←0, fresh_q←0; data fields don't-care (hold).
  - else stall=1: all fields hold; fresh_q←0.
  - else: capture all fields; valid_q←valid_in; fresh_q←valid_in.
- Write-back value wbv: mux of latched ALU/mem/Imm per WB[1:0]; 0 for 11.
- commit = valid_q & fresh_q & WB[2] & (WB[1:0] != 11).
- rf_we = commit. rf_waddr = latched rdst. rf_wdata = wbv. All three are combinational from state.
- A held (stalled) instruction writes only in its first occupied cycle; later cycles have rf_we=0.
- fwd_valid = valid_q & WB[2] & (WB[1:0] != 11). It stays asserted through stalls, so forwarding does not drop.
- fwd_addr = rdst, fwd_data = wbv.
- retired increments by 1 on each edge where valid_q & fresh_q, regardless of WB[2]. It wraps 0xFFFF→0x0000.
- sel_err is set on any edge where valid_q & fresh_q & WB[2] & WB[1:0]==11. It is cleared only by reset. The instruction retires but does not write.

## Timing
- Reset (rst=0, asynchronous, immediate): valid_q=0, fresh_q=0, all data fields 0, retired=0, sel_err=0. Hence rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, fwd_addr=0, fwd_data=0.
- Reset mid-operation discards the held instruction without a write, including when rst asserts in the same cycle as commit.
- Latency: data_in sampled at edge N drives rf_we/rf_wdata during cycle N→N+1. The register file writes at edge N+1.
- flush and stall both high: flush wins.
- valid_in=0 with no stall/flush: a bubble enters; no write, no retire.
- Back-to-back valid instructions commit on consecutive cycles, one per cycle.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0. Release, load valid ALU op (WB=100, ALU=0x1234, rdst=5) → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retired=1 after following edge.
- Source select: three consecutive valid ops with WB=100/101/110, ALU=0xAAAA, mem=0xBBBB, Imm=0xCCCC → rf_wdata sequence 0xAAAA, 0xBBBB, 0xCCCC on consecutive cycles, rf_we=1 each.
- Stall: load WB=101, mem=0x00FF, rdst=2, then stall=1 for 3 cycles:
  - rf_we=1 only in the first cycle, then 0.
  - fwd_valid=1, fwd_data=0x00FF throughout.
  - retired increments once.
- Flush: valid op loaded then flush=1 (with stall=1 simultaneously) → next cycle valid_q=0, rf_we=0, fwd_valid=0, retired unchanged.
- Illegal select: valid op WB=111 → rf_we=0, fwd_valid=0, sel_err=1 after edge and stays 1 across further legal ops until rst=0.
- Counter wrap: preload retired to 0xFFFF via 65535 valid ops (or force) → next valid op gives retired=0x0000. Ops with WB[2]=0 still count but rf_we=0.
